// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
module fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error
// flags and a choice of registered or first-word-fall-through read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        datain,
  input  logic                     w_en,
  input  logic                     r_en,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        dataout,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [clog2(DEPTH):0]    count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and at least 4");
  end
  if ((AE_THRESH >= AF_THRESH) || (AF_THRESH > DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_param: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end
  if (FWFT > FIFO_FWFT) begin : g_bad_mode
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end

  logic [AW:0]       w_ptr;
  logic [AW:0]       r_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // Status decoded from registered pointers; the MSB disambiguates full/empty.
  assign full         = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
  assign empty        = (w_ptr == r_ptr);
  assign count        = w_ptr - r_ptr;
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + CW'(1);
      if (rd_acc) r_ptr <= r_ptr + CW'(1);
    end
  end

  // Sticky errors: a new set in the same cycle takes priority over clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)  overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
      if (r_en && empty) underflow <= 1'b1;
      else if (clr_err)  underflow <= 1'b0;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && !rst),
    .waddr (w_ptr[AW-1:0]),
    .wdata (datain),
    .raddr (r_ptr[AW-1:0]),
    .rdata (mem_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign dataout  = empty ? '0 : mem_rdata;
    assign rd_valid = !empty;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;
    logic              vld_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= rd_acc;
        if (rd_acc) dout_q <= mem_rdata;
      end
    end

    assign dataout  = dout_q;
    assign rd_valid = vld_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: one standard-read and one FWFT instance of sync_fifo_param.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance
  logic       rst, w_en, r_en, clr_err;
  logic [7:0] datain, dataout;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  // FWFT instance
  logic       rst_f, w_en_f, r_en_f, clr_err_f;
  logic [7:0] datain_f, dataout_f;
  logic       rd_valid_f, full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
  logic [4:0] count_f;

  int checks   = 0;
  int failures = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .datain(datain), .w_en(w_en), .r_en(r_en), .clr_err(clr_err),
    .dataout(dataout), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst_f), .datain(datain_f), .w_en(w_en_f), .r_en(r_en_f), .clr_err(clr_err_f),
    .dataout(dataout_f), .rd_valid(rd_valid_f), .full(full_f), .empty(empty_f),
    .almost_full(almost_full_f), .almost_empty(almost_empty_f), .count(count_f),
    .overflow(overflow_f), .underflow(underflow_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; datain = 8'h00;
    rst_f = 1'b1; w_en_f = 1'b0; r_en_f = 1'b0; clr_err_f = 1'b0; datain_f = 8'h00;
    step();
    step();
    rst = 1'b0;
    rst_f = 1'b0;
    step();

    // Reset / idle state
    check("rst_empty",    32'(empty), 32'd1);
    check("rst_aempty",   32'(almost_empty), 32'd1);
    check("rst_count",    32'(count), 32'd0);
    check("rst_full",     32'(full), 32'd0);
    check("rst_afull",    32'(almost_full), 32'd0);
    check("rst_dataout",  32'(dataout), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_ovf",      32'(overflow), 32'd0);
    check("rst_unf",      32'(underflow), 32'd0);

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      datain = 8'(i);
      w_en   = 1'b1;
      step();
      check("fill_count",  32'(count), 32'(i));
      check("fill_aempty", 32'(almost_empty), 32'(i <= 2));
      check("fill_afull",  32'(almost_full), 32'(i >= 14));
      check("fill_full",   32'(full), 32'(i == 16));
      check("fill_empty",  32'(empty), 32'd0);
    end
    datain = 8'hAA;
    step();
    w_en = 1'b0;
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);

    // Drain, expecting 0x01..0x10 one cycle after each r_en
    for (int i = 1; i <= 16; i++) begin
      r_en = 1'b1;
      step();
      check("drain_data",  32'(dataout), 32'(i));
      check("drain_valid", 32'(rd_valid), 32'd1);
      check("drain_count", 32'(count), 32'(16 - i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    step();
    r_en = 1'b0;
    check("unf_set",   32'(underflow), 32'd1);
    check("unf_data",  32'(dataout), 32'h10);
    check("unf_valid", 32'(rd_valid), 32'd0);
    check("unf_count", 32'(count), 32'd0);
    step();
    check("hold_data", 32'(dataout), 32'h10);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // clr_err clears; a coincident set wins
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_unf", 32'(underflow), 32'd0);
    clr_err = 1'b1;
    r_en    = 1'b1;
    step();
    clr_err = 1'b0;
    r_en    = 1'b0;
    check("set_wins_unf", 32'(underflow), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_unf2", 32'(underflow), 32'd0);

    // Prime to 8 entries (0x20..0x27), then stream 40 cycles through the wrap
    w_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      datain = 8'(8'h20 + k);
      step();
    end
    check("prime_count", 32'(count), 32'd8);
    r_en = 1'b1;
    for (int j = 0; j < 40; j++) begin
      datain = 8'(8'h28 + j);
      step();
      check("stream_count", 32'(count), 32'd8);
      check("stream_data",  32'(dataout), 32'(8'h20 + j));
      check("stream_valid", 32'(rd_valid), 32'd1);
    end
    w_en = 1'b0;
    step();
    r_en = 1'b0;
    check("pre_rst_count", 32'(count), 32'd7);
    check("pre_rst_data",  32'(dataout), 32'h48);

    // Mid-stream reset overrides a concurrent write
    rst    = 1'b1;
    w_en   = 1'b1;
    datain = 8'hEE;
    step();
    rst  = 1'b0;
    w_en = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_data",  32'(dataout), 32'd0);
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    step();
    check("mid_rst_idle_count", 32'(count), 32'd0);

    // FWFT instance
    check("f_rst_empty", 32'(empty_f), 32'd1);
    check("f_rst_data",  32'(dataout_f), 32'd0);
    check("f_rst_valid", 32'(rd_valid_f), 32'd0);
    datain_f = 8'h5A;
    w_en_f   = 1'b1;
    step();
    w_en_f = 1'b0;
    check("f_head_data",  32'(dataout_f), 32'h5A);
    check("f_head_valid", 32'(rd_valid_f), 32'd1);
    check("f_head_count", 32'(count_f), 32'd1);
    datain_f = 8'h6B;
    w_en_f   = 1'b1;
    step();
    w_en_f = 1'b0;
    check("f_head_hold", 32'(dataout_f), 32'h5A);
    r_en_f = 1'b1;
    step();
    check("f_pop1_data", 32'(dataout_f), 32'h6B);
    step();
    r_en_f = 1'b0;
    check("f_pop2_empty", 32'(empty_f), 32'd1);
    check("f_pop2_data",  32'(dataout_f), 32'd0);
    check("f_pop2_valid", 32'(rd_valid_f), 32'd0);
    check("f_unf_clear",  32'(underflow_f), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
